// File: rtl/vga_display_bank.sv
// Double-buffered 16-entry display bank feeding the VGA controller.
// Back-bank writes publish on a VSync fall, then the new front is copied back.
module vga_display_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              WrValid,
  output logic              WrReady,
  input  logic              Commit,
  output logic              CommitPending,
  input  logic              VSync,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [DATA_W-1:0] RdData
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PENDING,
    S_COPY
  } state_t;

  state_t            state_q, state_d;
  logic              disp_sel_q, disp_sel_d;
  logic              vs_q, vs_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] bank_a_q [DEPTH];
  logic [DATA_W-1:0] bank_a_d [DEPTH];
  logic [DATA_W-1:0] bank_b_q [DEPTH];
  logic [DATA_W-1:0] bank_b_d [DEPTH];

  logic              vs_fall;
  logic              wr_fire;
  logic [DATA_W-1:0] copy_data;

  assign vs_fall       = vs_q & ~VSync;
  assign WrReady       = (state_q == S_IDLE);
  assign CommitPending = ~WrReady;
  assign wr_fire       = WrValid & WrReady;
  assign RdData        = rd_data_q;
  assign vs_d          = VSync;

  // disp_sel_q = 1 means bank B is the front
  assign copy_data = disp_sel_q ? bank_b_q[idx_q]
                                : bank_a_q[idx_q];

  always_comb begin
    state_d    = state_q;
    disp_sel_d = disp_sel_q;
    idx_d      = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (Commit) state_d = S_PENDING;
      end
      S_PENDING: begin
        if (vs_fall) begin
          disp_sel_d = ~disp_sel_q;
          idx_d      = '0;
          state_d    = S_COPY;
        end
      end
      S_COPY: begin
        idx_d = idx_q + 1'b1;
        if (&idx_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bank_a_d = bank_a_q;
    bank_b_d = bank_b_q;
    if (wr_fire) begin
      if (disp_sel_q) bank_a_d[WrAddr] = WrData;
      else            bank_b_d[WrAddr] = WrData;
    end
    if (state_q == S_COPY) begin
      if (disp_sel_q) bank_a_d[idx_q] = copy_data;
      else            bank_b_d[idx_q] = copy_data;
    end
  end

  always_comb begin
    rd_data_d = disp_sel_q ? bank_b_q[RdAddr]
                           : bank_a_q[RdAddr];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      disp_sel_q <= 1'b0;
      vs_q       <= 1'b1;
      idx_q      <= '0;
      rd_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bank_a_q[i] <= '0;
        bank_b_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      disp_sel_q <= disp_sel_d;
      vs_q       <= vs_d;
      idx_q      <= idx_d;
      rd_data_q  <= rd_data_d;
      bank_a_q   <= bank_a_d;
      bank_b_q   <= bank_b_d;
    end
  end

endmodule

// File: tb/tb_vga_display_bank.sv
// Scoreboard bench for vga_display_bank against a two-array
// model: a swap makes the written contents the displayed contents.
module tb_vga_display_bank;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] WrAddr = '0;
  logic [7:0] WrData = '0;
  logic       WrValid = 1'b0;
  logic       WrReady;
  logic       Commit = 1'b0;
  logic       CommitPending;
  logic       VSync = 1'b1;
  logic [3:0] RdAddr = '0;
  logic [7:0] RdData;

  vga_display_bank dut (
    .CLK(CLK),
    .RESET(RESET),
    .WrAddr(WrAddr),
    .WrData(WrData),
    .WrValid(WrValid),
    .WrReady(WrReady),
    .Commit(Commit),
    .CommitPending(CommitPending),
    .VSync(VSync),
    .RdAddr(RdAddr),
    .RdData(RdData)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] rd;
    logic       rdy;
    logic       pend;
  } exp_t;

  exp_t sbq[$];

  logic [7:0] disp_m [16];
  logic [7:0] back_m [16];
  int         mode_m;
  int         copy_left;
  logic       vs_prev;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("rd_data", RdData, e.rd);
      check("wr_ready", WrReady, e.rdy);
      check("commit_pending", CommitPending, e.pend);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      disp_m[i] = 8'h00;
      back_m[i] = 8'h00;
    end
    mode_m    = 0;
    copy_left = 0;
    vs_prev   = 1'b1;
  endtask

  task automatic step(input logic wv, input logic [3:0] wa,
                      input logic [7:0] wd, input logic cm,
                      input logic vs, input logic [3:0] ra);
    exp_t e;
    logic fall;
    @(negedge CLK);
    #1;
    WrValid = wv;
    WrAddr  = wa;
    WrData  = wd;
    Commit  = cm;
    VSync   = vs;
    RdAddr  = ra;
    e.rd    = disp_m[ra];
    fall    = vs_prev & ~vs;
    vs_prev = vs;
    case (mode_m)
      0: begin
        if (wv) back_m[wa] = wd;
        if (cm) mode_m = 1;
      end
      1: begin
        if (fall) begin
          // back keeps its contents: it is refilled from the new front
          for (int i = 0; i < 16; i++) disp_m[i] = back_m[i];
          mode_m    = 2;
          copy_left = 16;
        end
      end
      default: begin
        copy_left--;
        if (copy_left == 0) mode_m = 0;
      end
    endcase
    e.rdy  = (mode_m == 0);
    e.pend = (mode_m != 0);
    sbq.push_back(e);
  endtask

  task automatic idle(input int n, input logic vs, input int ra);
    for (int i = 0; i < n; i++) begin
      logic [3:0] a;
      a = (ra < 0) ? 4'($urandom_range(0, 15)) : 4'(ra);
      step(1'b0, 4'd0, 8'd0, 1'b0, vs, a);
    end
  endtask

  task automatic sweep(input logic vs);
    for (int i = 0; i < 16; i++)
      step(1'b0, 4'd0, 8'd0, 1'b0, vs, 4'(i));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #1;
    WrValid = 1'b0;
    Commit  = 1'b0;
    VSync   = 1'b1;
    RESET   = 1'b1;
    #1;
    check("rst_wr_ready", WrReady, 1);
    check("rst_pending", CommitPending, 0);
    check("rst_rd_data", RdData, 0);
    model_reset();
    @(negedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    logic vs;
    model_reset();
    do_reset();
    sweep(1'b1);

    step(1'b1, 4'd3, 8'h5A, 1'b0, 1'b1, 4'd3);
    step(1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd3);
    idle(3, 1'b1, 3);
    step(1'b1, 4'd2, 8'hFF, 1'b1, 1'b1, 4'd3);
    idle(2, 1'b1, 3);
    step(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd3);
    step(1'b1, 4'd2, 8'hFF, 1'b0, 1'b0, 4'd3);
    step(1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd3);
    idle(20, 1'b0, 3);
    idle(2, 1'b1, -1);
    sweep(1'b1);

    step(1'b1, 4'd7, 8'h11, 1'b0, 1'b1, 4'd7);
    step(1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd7);
    idle(2, 1'b1, 7);
    step(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd7);
    idle(18, 1'b0, 2);
    sweep(1'b0);

    idle(3, 1'b0, -1);
    step(1'b1, 4'd0, 8'h42, 1'b1, 1'b0, 4'd0);
    idle(6, 1'b0, 0);
    idle(2, 1'b1, 0);
    step(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    idle(18, 1'b0, 0);
    sweep(1'b1);

    step(1'b1, 4'd9, 8'hC3, 1'b1, 1'b1, 4'd9);
    idle(2, 1'b1, 9);
    step(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd9);
    idle(8, 1'b0, 9);
    do_reset();
    sweep(1'b1);

    vs = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) vs = ~vs;
      step($urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)),
           $urandom_range(0, 15) == 0,
           vs,
           4'($urandom_range(0, 15)));
    end

    idle(2, 1'b1, -1);
    repeat (2) @(negedge CLK);
    #1;
    check("sb_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
